mem_master: RTL and testbench

Bus initiator for the data-memory port of the CPU. It turns pipeline load/store requests (byte, half, word; signed or unsigned) into CS/WE/ADDR/Mem_Bus transactions toward the word-addressed, negedge-clocked memory. It generates byte enables, aligns store data, and extends load data. Optionally it splits accesses that cross a word boundary into two bus cycles.

---
 rtl/mem_master.sv | 193 +++++++++++++++++++
 tb/tb_mem_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_master.sv
// mem_master: load/store bus initiator for the word-addressed, negedge-clocked data memory.
// Define MEM_MASTER_MISALIGNED_SPLIT_EN to split word-crossing accesses into two bus cycles.
module mem_master #(
  parameter int WADDR_W = 30
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        CS,
  output logic [3:0]  WE,
  output logic [31:0] ADDR,
  inout  wire  [31:0] Mem_Bus
);

`ifdef MEM_MASTER_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t state_reg, state_next;

  logic        we_reg, uns_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg, wdata_reg, lo_reg, lo_next;

  logic        req_ready_reg, req_ready_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic        rsp_err_reg, rsp_err_next;
  logic [31:0] rsp_rdata_reg, rsp_rdata_next;
  logic        cs_reg, cs_next;
  logic [3:0]  be_reg, be_next;
  logic [31:0] addr_out_reg, addr_out_next;
  logic [31:0] bus_reg, bus_next;
  logic        drive_reg, drive_next;

  // In IDLE the request is decoded straight from the inputs; afterwards from the latched copy.
  logic               src_we, src_uns, accept, split, bad;
  logic [1:0]         src_size, off;
  logic [31:0]        src_addr, src_wdata, ld_word, ld_result;
  logic [3:0]         base_mask;
  logic [7:0]         mask8;
  logic [63:0]        wide, ld64;
  logic [WADDR_W-1:0] waddr, waddr_inc;

  function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [1:0] size,
                                              input logic uns);
    logic [31:0] r;
    case (size)
      2'b00:   r = {{24{~uns & d[7]}}, d[7:0]};
      2'b01:   r = {{16{~uns & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign accept    = (state_reg == IDLE) && req_valid && req_ready_reg;
  assign src_we    = (state_reg == IDLE) ? req_we       : we_reg;
  assign src_uns   = (state_reg == IDLE) ? req_unsigned : uns_reg;
  assign src_size  = (state_reg == IDLE) ? req_size     : size_reg;
  assign src_addr  = (state_reg == IDLE) ? req_addr     : addr_reg;
  assign src_wdata = (state_reg == IDLE) ? req_wdata    : wdata_reg;

  assign off       = src_addr[1:0];
  assign base_mask = (src_size == 2'b00) ? 4'b0001 :
                     (src_size == 2'b01) ? 4'b0011 :
                     (src_size == 2'b10) ? 4'b1111 : 4'b0000;
  assign mask8     = {4'b0000, base_mask} << off;
  assign split     = |mask8[7:4];
  assign bad       = (src_size == 2'b11) || (split && !SPLIT_EN);
  assign wide      = {32'h0, src_wdata} << {off, 3'b000};
  assign waddr     = src_addr[WADDR_W+1:2];
  assign waddr_inc = waddr + WADDR_W'(1);

  // The second half of a split load arrives on the bus while the first half sits in lo_reg.
  assign ld64      = (state_reg == ACC1) ? {Mem_Bus, lo_reg} : {32'h0, Mem_Bus};
  assign ld_word   = 32'(ld64 >> {off, 3'b000});
  assign ld_result = extend_load(ld_word, src_size, src_uns);

  always_comb begin
    state_next     = state_reg;
    lo_next        = lo_reg;
    cs_next        = 1'b0;
    be_next        = 4'b0000;
    addr_out_next  = 32'h0;
    bus_next       = 32'h0;
    drive_next     = 1'b0;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = 32'h0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (bad) begin
            state_next     = RESP;
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
          end else begin
            state_next    = ACC0;
            cs_next       = 1'b1;
            be_next       = src_we ? mask8[3:0] : 4'b0000;
            addr_out_next = 32'(waddr);
            bus_next      = wide[31:0];
            drive_next    = src_we;
          end
        end
      end
      ACC0: begin
        lo_next = Mem_Bus;
        if (SPLIT_EN && split) begin
          state_next    = ACC1;
          cs_next       = 1'b1;
          be_next       = src_we ? mask8[7:4] : 4'b0000;
          addr_out_next = 32'(waddr_inc);
          bus_next      = wide[63:32];
          drive_next    = src_we;
        end else begin
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = src_we ? 32'h0 : ld_result;
        end
      end
      ACC1: begin
        state_next     = RESP;
        rsp_valid_next = 1'b1;
        rsp_rdata_next = src_we ? 32'h0 : ld_result;
      end
      default: state_next = IDLE;
    endcase
    req_ready_next = (state_next == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      uns_reg       <= 1'b0;
      size_reg      <= 2'b00;
      addr_reg      <= 32'h0;
      wdata_reg     <= 32'h0;
      lo_reg        <= 32'h0;
      req_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= 32'h0;
      cs_reg        <= 1'b0;
      be_reg        <= 4'b0000;
      addr_out_reg  <= 32'h0;
      bus_reg       <= 32'h0;
      drive_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lo_reg        <= lo_next;
      req_ready_reg <= req_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
      cs_reg        <= cs_next;
      be_reg        <= be_next;
      addr_out_reg  <= addr_out_next;
      bus_reg       <= bus_next;
      drive_reg     <= drive_next;
      if (accept) begin
        we_reg    <= req_we;
        uns_reg   <= req_unsigned;
        size_reg  <= req_size;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign CS        = cs_reg;
  assign WE        = be_reg;
  assign ADDR      = addr_out_reg;
  assign Mem_Bus   = drive_reg ? bus_reg : 32'hz;

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: directed table, reset-abort sequence and randomized traffic against a byte-level model.
`timescale 1ns/1ps
module tb_mem_master;

`ifdef MEM_MASTER_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  wire         req_ready, rsp_valid, rsp_err, CS;
  wire  [31:0] rsp_rdata, ADDR;
  wire  [3:0]  WE;
  wire  [31:0] mem_bus;

  always #5 CLK = ~CLK;

  mem_master dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .CS(CS), .WE(WE), .ADDR(ADDR), .Mem_Bus(mem_bus)
  );

  function automatic logic [31:0] init_word(input int w);
    case (w)
      0:       return 32'h55667788;
      1:       return 32'h8899AABB;
      2:       return 32'hCCDDEEFF;
      255:     return 32'h11223344;
      default: return 32'h0;
    endcase
  endfunction

  // Negedge-clocked word memory (256 words, ADDR aliased on its low 8 bits).
  logic [31:0] ram [256];
  logic [31:0] mem_q = 32'h0;
  logic        mem_drive = 1'b0;
  bit          ram_loaded = 1'b0;
  assign mem_bus = mem_drive ? mem_q : 32'hz;

  always @(negedge CLK) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
      mem_drive  <= 1'b0;
    end else if (CS) begin
      if (WE == 4'b0000) begin
        mem_q     <= ram[ADDR[7:0]];
        mem_drive <= 1'b1;
      end else begin
        for (int l = 0; l < 4; l++)
          if (WE[l]) ram[ADDR[7:0]][8*l +: 8] <= mem_bus[8*l +: 8];
        mem_drive <= 1'b0;
      end
    end else begin
      mem_drive <= 1'b0;
    end
  end

  // Bus cycle recorder: ring of the last 16 CS cycles.
  int          cs_total = 0;
  logic [31:0] mon_addr [16];
  logic [31:0] mon_bus  [16];
  logic [3:0]  mon_we   [16];
  always @(negedge CLK) begin
    if (CS) begin
      mon_addr[cs_total[3:0]] <= ADDR;
      mon_bus[cs_total[3:0]]  <= mem_bus;
      mon_we[cs_total[3:0]]   <= WE;
      cs_total <= cs_total + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: plain byte array, little-endian, byte address bits [9:0].
  logic [7:0] ref_mem [1024];

  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err, output int ncs);
    int n;
    logic [31:0] a;
    logic [63:0] v;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    err = (n == 0) || ((int'(addr[1:0]) + n > 4) && !SPLIT);
    ncs = err ? 0 : ((int'(addr[1:0]) + n > 4) ? 2 : 1);
    rd  = 32'h0;
    v   = 64'h0;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        if (we) ref_mem[a[9:0]] = wdata[8*i +: 8];
        else    v[8*i +: 8] = ref_mem[a[9:0]];
      end
      if (!we) begin
        if (!uns && v[8*n-1]) v = v | (~64'h0 << (8*n));
        rd = v[31:0];
      end
    end
  endtask

  task automatic run_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic err, output int lat,
                         output int ncs, output int first);
    int guard, start;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge CLK); #1;
      guard++;
    end
    chk($sformatf("%s ready_wait", tag), 32'(guard < 20), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    start = cs_total;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 8) begin
      @(posedge CLK); #1;
      lat++;
    end
    rd    = rsp_rdata;
    err   = rsp_err;
    ncs   = cs_total - start;
    first = start;
    @(posedge CLK); #1;
    chk($sformatf("%s pulse", tag), 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_ncs;
    logic [31:0] exp_addr0;
    logic [3:0]  exp_we0;
    logic [31:0] exp_bus0;
  } vec_t;

  localparam logic [31:0] SP_W7   = SPLIT ? 32'hDDEEFF88 : 32'h0;
  localparam logic [31:0] SP_HFF  = SPLIT ? 32'hFFFF8811 : 32'h0;
  localparam logic [31:0] SP_W0   = SPLIT ? 32'h33447788 : 32'h55667788;
  localparam logic [31:0] SP_W4   = SPLIT ? 32'hBEEF1122 : 32'hBEEFAABB;
  localparam logic        SP_ERR  = !SPLIT;
  localparam int          SP_N    = SPLIT ? 2 : 0;

  vec_t        tbl [15];
  logic [31:0] rd, e_rd;
  logic        err, e_err;
  int          lat, ncs, e_ncs, first;
  logic        r_we, r_uns;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, w;

  initial begin
    for (int wi = 0; wi < 256; wi++) begin
      w = init_word(wi);
      for (int l = 0; l < 4; l++) ref_mem[wi*4 + l] = w[8*l +: 8];
    end

    //            we  size  uns  addr          wdata         exp_rd        err     ncs   addr0         we0      bus0
    tbl[0]  = '{1'b0, 2'd2, 1'b0, 32'h4,        32'h0,        32'h8899AABB, 1'b0,   1,    32'h1,        4'b0000, 32'h0};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h7,        32'h0,        32'hFFFFFF88, 1'b0,   1,    32'h1,        4'b0000, 32'h0};
    tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h7,        32'h0,        32'h00000088, 1'b0,   1,    32'h1,        4'b0000, 32'h0};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 32'h7,        32'h0,        SP_W7,        SP_ERR, SP_N, 32'h1,        4'b0000, 32'h0};
    tbl[4]  = '{1'b1, 2'd1, 1'b0, 32'h6,        32'h1234BEEF, 32'h0,        1'b0,   1,    32'h1,        4'b1100, 32'hBEEF0000};
    tbl[5]  = '{1'b0, 2'd2, 1'b1, 32'h4,        32'h0,        32'hBEEFAABB, 1'b0,   1,    32'h1,        4'b0000, 32'h0};
    tbl[6]  = '{1'b0, 2'd3, 1'b0, 32'h8,        32'h0,        32'h0,        1'b1,   0,    32'h0,        4'b0000, 32'h0};
    tbl[7]  = '{1'b1, 2'd3, 1'b0, 32'h8,        32'hFFFFFFFF, 32'h0,        1'b1,   0,    32'h0,        4'b0000, 32'h0};
    tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h5,        32'h0,        32'hFFFFEFAA, 1'b0,   1,    32'h1,        4'b0000, 32'h0};
    tbl[9]  = '{1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0,        SP_HFF,       SP_ERR, SP_N, 32'h3FFFFFFF, 4'b0000, 32'h0};
    tbl[10] = '{1'b0, 2'd2, 1'b1, 32'h8,        32'h0,        32'hCCDDEEFF, 1'b0,   1,    32'h2,        4'b0000, 32'h0};
    tbl[11] = '{1'b1, 2'd0, 1'b0, 32'h9,        32'hFFFFFFA5, 32'h0,        1'b0,   1,    32'h2,        4'b0010, 32'hFFFFA500};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h8,        32'h0,        32'hCCDDA5FF, 1'b0,   1,    32'h2,        4'b0000, 32'h0};
    tbl[13] = '{1'b1, 2'd2, 1'b0, 32'h2,        32'h11223344, 32'h0,        SP_ERR, SP_N, 32'h0,        4'b1100, 32'h33440000};
    tbl[14] = '{1'b0, 2'd2, 1'b0, 32'h0,        32'h0,        SP_W0,        1'b0,   1,    32'h0,        4'b0000, 32'h0};

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'h0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    chk("rst CS", 32'(CS), 32'd0);
    chk("rst WE", 32'(WE), 32'd0);
    chk("rst ADDR", ADDR, 32'h0);
    RST = 1'b0;
    chk("post_rst ready_low", 32'(req_ready), 32'd0);
    @(posedge CLK); #1;
    chk("post_rst ready_high", 32'(req_ready), 32'd1);

    for (int i = 0; i < 15; i++) begin
      model(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, e_rd, e_err, e_ncs);
      run_req($sformatf("vec%0d", i), tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr,
              tbl[i].wdata, rd, err, lat, ncs, first);
      chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d err", i), 32'(err), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d cs_cycles", i), 32'(ncs), 32'(tbl[i].exp_ncs));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].exp_ncs));
      if (tbl[i].exp_ncs > 0) begin
        chk($sformatf("vec%0d addr0", i), mon_addr[first % 16], tbl[i].exp_addr0);
        chk($sformatf("vec%0d we0", i), 32'(mon_we[first % 16]), 32'(tbl[i].exp_we0));
        if (tbl[i].we) chk($sformatf("vec%0d bus0", i), mon_bus[first % 16], tbl[i].exp_bus0);
      end
`ifdef MEM_MASTER_MISALIGNED_SPLIT_EN
      if (i == 9) chk("wrap addr1", mon_addr[(first + 1) % 16], 32'h0);
      if (i == 13) chk("split store we1", 32'(mon_we[(first + 1) % 16]), 32'h3);
`endif
    end
    run_req("vec_w4", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, err, lat, ncs, first);
    chk("vec_w4 rdata", rd, SP_W4);

    // Reset during the last access cycle of a load: access aborted, no response.
    while (!req_ready) begin @(posedge CLK); #1; end
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = SPLIT ? 32'h7 : 32'h4;
    @(posedge CLK); #1;
    req_valid = 1'b0;
`ifdef MEM_MASTER_MISALIGNED_SPLIT_EN
    @(posedge CLK); #1;
`endif
    chk("abort cs_before", 32'(CS), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("abort cs_after", 32'(CS), 32'd0);
    chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
    RST = 1'b0;
    chk("abort ready_low", 32'(req_ready), 32'd0);
    @(posedge CLK); #1;
    chk("abort ready_high", 32'(req_ready), 32'd1);
    chk("abort no_rsp", 32'(rsp_valid), 32'd0);

    // Randomized traffic against the byte model.
    for (int k = 0; k < 200; k++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_size  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_uns   = 1'($urandom_range(0, 1));
      r_addr  = ($urandom_range(0, 9) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3)))
                                            : 32'($urandom_range(0, 1023));
      r_wdata = $urandom;
      model(r_we, r_size, r_uns, r_addr, r_wdata, e_rd, e_err, e_ncs);
      run_req($sformatf("rnd%0d", k), r_we, r_size, r_uns, r_addr, r_wdata, rd, err, lat, ncs, first);
      chk($sformatf("rnd%0d rdata a=%08h sz=%0d", k, r_addr, r_size), rd, e_rd);
      chk($sformatf("rnd%0d err", k), 32'(err), 32'(e_err));
      chk($sformatf("rnd%0d latency", k), 32'(lat), 32'(e_ncs));
      chk($sformatf("rnd%0d cs_cycles", k), 32'(ncs), 32'(e_ncs));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
